ps2_key_tracker: RTL and testbench
==================================

// Module: ps2_key_tracker
// PURPOSE
//  Sits between the PS/2 frame receiver (one byte per valid pulse) and the
//  scancode/seven-segment display path. Parses make, break (F0) and extended
//  (E0) sequences and holds the current key code and its pressed state.
//  Counts distinct key presses (typematic repeats excluded) for the count digits.
// PARAMETERS
//  CNT_W       16      width of press counter
//  TIMEOUT_CYC 65535   max idle cycles inside an F0/E0 prefix before abort (>=1)
//  BREAK_CODE  8'hF0   break prefix byte
//  EXT_CODE    8'hE0   extended prefix byte
// PORTS
//  clk          in   1      system clock, all logic on posedge
//  reset        in   1      synchronous, active-high
//  byte_valid   in   1      one-cycle strobe: byte_data holds a received byte
//  byte_data    in   8      received scancode byte
//  key_code     out  8      code of most recently pressed key (held)
//  key_ext      out  1      1 = key_code is an E0-extended key
//  key_down     out  1      1 = key_code currently held; drives display enable
//  press_cnt    out  CNT_W  number of distinct presses, wraps modulo 2^CNT_W
//  press_pulse  out  1      one-cycle pulse when press_cnt increments
//  err_pulse    out  1      one-cycle pulse on protocol error or prefix timeout
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; timeout counter 0. Reset wins over all
//    inputs and aborts any partial sequence.
//  - All outputs registered; update in the cycle after the byte_valid cycle.
//  - byte_data ignored when byte_valid=0. Pulses last exactly one cycle.
//  - FSM states: IDLE, BRK, EXT, EXT_BRK. On byte_valid:
//    IDLE:    F0 -> BRK; E0 -> EXT; other byte b -> MAKE(b, ext=0).
//    EXT:     F0 -> EXT_BRK; E0 -> error; other b -> MAKE(b, ext=1), IDLE.
//    BRK:     F0/E0 -> error; other b -> BREAK(b, ext=0), IDLE.
//    EXT_BRK: F0/E0 -> error; other b -> BREAK(b, ext=1), IDLE.
//  - MAKE(b,e): if key_down=1 and key_code==b and key_ext==e -> typematic
//    repeat: no output change, no count. Otherwise key_code<=b, key_ext<=e,
//    key_down<=1, press_cnt+=1, press_pulse=1 (rollover to new key counts).
//  - BREAK(b,e): if key_code==b and key_ext==e -> key_down<=0 (code/ext held).
//    Else (release of non-tracked key) no output change, no error.
//  - error: err_pulse=1, byte discarded, state -> IDLE, key outputs unchanged.
//  - Timeout: counter clears on every byte_valid and in IDLE; increments each
//    cycle in BRK/EXT/EXT_BRK. When it reaches TIMEOUT_CYC with no byte_valid
//    that cycle -> err_pulse=1, state IDLE. byte_valid in the same cycle wins.
//  - press_cnt at 2^CNT_W-1 wraps to 0 on next press; press_pulse still fires.
//  - press_pulse and err_pulse never assert in the same cycle.
// TESTING
//  1 reset then bytes 1C,F0,1C -> key_code=1C,key_down=1,press_cnt=1 after
//    first byte; key_down=0 after third; press_cnt stays 1, key_code stays 1C.
//  2 typematic: 16,16,16,F0,16 -> press_cnt=1, one press_pulse, key_down=0 end.
//  3 extended: E0,75,E0,F0,75 -> key_code=75,key_ext=1,key_down 1 then 0;
//    plain F0,75 while E0 75 held -> key_down stays 1.
//  4 rollover: 1C then 32 -> press_cnt=2, key_code=32; F0,1C -> key_down=1.
//  5 errors: F0,F0 -> err_pulse once, state IDLE, then 1C registers as make;
//    TIMEOUT_CYC=8, E0 then idle -> err_pulse 8 cycles after the E0 is taken.
//  6 CNT_W=4: 16 distinct presses -> press_cnt 15 then 0; reset asserted after
//    F0 -> next byte 1C is a make (press_cnt=1, key_down=1).

Source files
------------

// File: rtl/ps2_key_tracker.sv
// ---------------------------------------------------------------------------
// ps2_key_tracker
//
// Purpose:
//   Takes scancode bytes from a PS/2 frame receiver, one byte per byte_valid
//   strobe. It parses make codes, break (F0) sequences and extended (E0)
//   sequences. It holds the current key code and whether that key is pressed.
//   It also counts distinct key presses; typematic repeats are not counted.
//
// Ports:
//   clk          in   1      system clock, all logic on posedge
//   reset        in   1      synchronous, active-high
//   byte_valid   in   1      one-cycle strobe, byte_data is valid
//   byte_data    in   8      received scancode byte
//   key_code     out  8      code of most recently pressed key (held)
//   key_ext      out  1      key_code is an E0-extended key
//   key_down     out  1      key_code is currently held
//   press_cnt    out  CNT_W  distinct presses, wraps modulo 2^CNT_W
//   press_pulse  out  1      one-cycle pulse when press_cnt increments
//   err_pulse    out  1      one-cycle pulse on protocol error or timeout
// ---------------------------------------------------------------------------
module ps2_key_tracker #(
    parameter int          CNT_W       = 16,
    parameter int          TIMEOUT_CYC = 65535,
    parameter logic [7:0]  BREAK_CODE  = 8'hF0,
    parameter logic [7:0]  EXT_CODE    = 8'hE0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_down,
    output logic [CNT_W-1:0] press_cnt,
    output logic             press_pulse,
    output logic             err_pulse
);

    // The counter must be able to hold TIMEOUT_CYC-1. The abort fires when one
    // more idle cycle would bring it up to TIMEOUT_CYC.
    localparam int              TO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BRK     = 2'd1,
        S_EXT     = 2'd2,
        S_EXT_BRK = 2'd3
    } state_t;

    state_t           r_state;
    logic [TO_W-1:0]  r_to_cnt;
    logic [7:0]       r_key_code;
    logic             r_key_ext;
    logic             r_key_down;
    logic [CNT_W-1:0] r_press_cnt;
    logic             r_press_pulse;
    logic             r_err_pulse;

    logic w_is_brk;
    logic w_is_ext;
    logic w_make_ext;
    logic w_brk_ext;
    logic w_repeat;
    logic w_brk_match;

    always_comb begin
        w_is_brk    = (byte_data == BREAK_CODE);
        w_is_ext    = (byte_data == EXT_CODE);
        // A make can only come from IDLE or EXT. A break can only come from BRK
        // or EXT_BRK. So the ext flag for each case depends only on the state.
        w_make_ext  = (r_state == S_EXT);
        w_brk_ext   = (r_state == S_EXT_BRK);
        // The same key sent again while it is still held is a typematic repeat.
        w_repeat    = r_key_down && (r_key_code == byte_data) && (r_key_ext == w_make_ext);
        w_brk_match = (r_key_code == byte_data) && (r_key_ext == w_brk_ext);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_to_cnt      <= '0;
            r_key_code    <= '0;
            r_key_ext     <= 1'b0;
            r_key_down    <= 1'b0;
            r_press_cnt   <= '0;
            r_press_pulse <= 1'b0;
            r_err_pulse   <= 1'b0;
        end else begin
            r_press_pulse <= 1'b0;
            r_err_pulse   <= 1'b0;

            if (byte_valid) begin
                // A byte that arrives in the same cycle as the timeout wins.
                r_to_cnt <= '0;
                case (r_state)
                    S_IDLE, S_EXT: begin
                        if (w_is_brk) begin
                            r_state <= (r_state == S_EXT) ? S_EXT_BRK : S_BRK;
                        end else if (w_is_ext) begin
                            if (r_state == S_EXT) begin
                                r_err_pulse <= 1'b1;
                                r_state     <= S_IDLE;
                            end else begin
                                r_state <= S_EXT;
                            end
                        end else begin
                            r_state <= S_IDLE;
                            if (!w_repeat) begin
                                r_key_code    <= byte_data;
                                r_key_ext     <= w_make_ext;
                                r_key_down    <= 1'b1;
                                r_press_cnt   <= r_press_cnt + 1'b1;
                                r_press_pulse <= 1'b1;
                            end
                        end
                    end
                    S_BRK, S_EXT_BRK: begin
                        r_state <= S_IDLE;
                        if (w_is_brk || w_is_ext) begin
                            r_err_pulse <= 1'b1;
                        end else if (w_brk_match) begin
                            r_key_down <= 1'b0;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end else if (r_state != S_IDLE) begin
                if (r_to_cnt == TO_LAST) begin
                    r_err_pulse <= 1'b1;
                    r_state     <= S_IDLE;
                    r_to_cnt    <= '0;
                end else begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    assign key_code    = r_key_code;
    assign key_ext     = r_key_ext;
    assign key_down    = r_key_down;
    assign press_cnt   = r_press_cnt;
    assign press_pulse = r_press_pulse;
    assign err_pulse   = r_err_pulse;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_tracker
//
// Purpose:
//   Directed bench for ps2_key_tracker, built with CNT_W=4 and TIMEOUT_CYC=8.
//   Each scancode byte is applied as one byte_valid strobe. Outputs are
//   sampled on the falling edge that follows the capturing rising edge.
// ---------------------------------------------------------------------------
module tb_ps2_key_tracker;

    localparam int CNT_W = 4;
    localparam int TO    = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             byte_valid = 1'b0;
    logic [7:0]       byte_data = 8'h00;
    logic [7:0]       key_code;
    logic             key_ext;
    logic             key_down;
    logic [CNT_W-1:0] press_cnt;
    logic             press_pulse;
    logic             err_pulse;

    int n_total = 0;
    int n_bad   = 0;
    int n_press = 0;
    int n_err   = 0;

    ps2_key_tracker #(
        .CNT_W       (CNT_W),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .key_code    (key_code),
        .key_ext     (key_ext),
        .key_down    (key_down),
        .press_cnt   (press_cnt),
        .press_pulse (press_pulse),
        .err_pulse   (err_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one byte for one cycle. Return on the next falling edge, when the
    // registered result can be read. Also count the pulses it caused.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        @(negedge clk);
        byte_valid = 1'b0;
        if (press_pulse) n_press++;
        if (err_pulse)   n_err++;
        $display("tx byte=%02h code=%02h ext=%0d down=%0d cnt=%0d pp=%0d ep=%0d",
                 b, key_code, key_ext, key_down, press_cnt, press_pulse, err_pulse);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n_press = 0;
        n_err   = 0;
    endtask

    initial begin
        int wait_n;
        logic seen;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_code", key_code, 8'h00);
        chk("rst_ext",  key_ext, 1'b0);
        chk("rst_down", key_down, 1'b0);
        chk("rst_cnt",  press_cnt, 0);
        chk("rst_pp",   press_pulse, 1'b0);
        chk("rst_ep",   err_pulse, 1'b0);
        reset = 1'b0;

        // 1: make then break
        do_reset();
        send(8'h1C);
        chk("t1_code", key_code, 8'h1C);
        chk("t1_down", key_down, 1'b1);
        chk("t1_cnt",  press_cnt, 1);
        chk("t1_pp",   press_pulse, 1'b1);
        send(8'hF0);
        chk("t1_pp_f0", press_pulse, 1'b0);
        chk("t1_down_f0", key_down, 1'b1);
        send(8'h1C);
        chk("t1_up",     key_down, 1'b0);
        chk("t1_cnt2",   press_cnt, 1);
        chk("t1_code2",  key_code, 8'h1C);

        // 2: typematic repeats do not count
        do_reset();
        send(8'h16); send(8'h16); send(8'h16); send(8'hF0); send(8'h16);
        chk("t2_cnt",    press_cnt, 1);
        chk("t2_pulses", n_press, 1);
        chk("t2_down",   key_down, 1'b0);

        // 3: extended key; a plain break of the same code does not release it
        do_reset();
        send(8'hE0); send(8'h75);
        chk("t3_code", key_code, 8'h75);
        chk("t3_ext",  key_ext, 1'b1);
        chk("t3_down", key_down, 1'b1);
        send(8'hF0); send(8'h75);
        chk("t3_plainbrk", key_down, 1'b1);
        chk("t3_cnt", press_cnt, 1);
        send(8'hE0); send(8'hF0); send(8'h75);
        chk("t3_up",   key_down, 1'b0);
        chk("t3_ext2", key_ext, 1'b1);

        // 4: rolling over to a new key; releasing the old key has no effect
        do_reset();
        send(8'h1C); send(8'h32);
        chk("t4_cnt",  press_cnt, 2);
        chk("t4_code", key_code, 8'h32);
        send(8'hF0); send(8'h1C);
        chk("t4_down", key_down, 1'b1);
        chk("t4_err",  n_err, 0);

        // 5: double break prefix is an error, then normal parsing resumes
        do_reset();
        send(8'hF0); send(8'hF0);
        chk("t5_ep", err_pulse, 1'b1);
        chk("t5_pp", press_pulse, 1'b0);
        send(8'h1C);
        chk("t5_errs", n_err, 1);
        chk("t5_code", key_code, 8'h1C);
        chk("t5_down", key_down, 1'b1);
        chk("t5_cnt",  press_cnt, 1);
        // Prefix timeout: the error should appear TO cycles after E0 is taken
        send(8'hE0);
        wait_n = 0;
        seen = 1'b0;
        while (!seen && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
            if (err_pulse) seen = 1'b1;
        end
        chk("t5_to_seen", seen, 1'b1);
        chk("t5_to_cyc",  wait_n, TO);
        @(negedge clk);
        chk("t5_to_1cyc", err_pulse, 1'b0);
        // The parser is back in IDLE, so this is a plain (not extended) make
        send(8'h75);
        chk("t5_post_ext",  key_ext, 1'b0);
        chk("t5_post_code", key_code, 8'h75);
        chk("t5_post_cnt",  press_cnt, 2);

        // 6: press counter wraps; reset aborts a pending break prefix
        do_reset();
        for (int i = 1; i <= 15; i++) send(8'(i));
        chk("t6_cnt15", press_cnt, 15);
        send(8'h10);
        chk("t6_wrap", press_cnt, 0);
        chk("t6_wrap_pp", press_pulse, 1'b1);
        send(8'hF0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t6_rst_cnt", press_cnt, 0);
        send(8'h1C);
        chk("t6_make_cnt",  press_cnt, 1);
        chk("t6_make_down", key_down, 1'b1);
        chk("t6_make_code", key_code, 8'h1C);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
